// File: rtl/lsu_bus_arb_pkg.sv
// Shared types and bus widths for the LSU data-memory bus arbiter.
package lsu_bus_arb_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int SIZE_WIDTH     = 4;
    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } lsu_bus_arb_state_t;

endpackage

// File: rtl/lsu_bus_arb_starve_counter.sv
// Saturating count of read grants taken while a write waits.
// Only instantiated when LSU_BUS_ARB_STARVATION_GUARD_EN is defined.
module lsu_bus_arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_reached
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && cnt < LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_reached = (cnt >= LIM);

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Arbitrates the single data-memory port between store-buffer reads and drain writes.
// Optional write-starvation guard: LSU_BUS_ARB_STARVATION_GUARD_EN.
module lsu_bus_arbiter
    import lsu_bus_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
    input  logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size,
    input  logic                      stbuf_bus_read_req,
    output logic [REG_DATA_WIDTH-1:0] bus_stbuf_data,
    output logic                      bus_stbuf_read_ack,
    input  logic [ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
    input  logic [SIZE_WIDTH-1:0]     stbuf_bus_write_size,
    input  logic [REG_DATA_WIDTH-1:0] stbuf_bus_data,
    input  logic                      stbuf_bus_write_req,
    output logic                      bus_stbuf_write_ack,
    input  logic                      drain_req,
    input  logic                      flush,
    output logic [ADDR_WIDTH-1:0]     arb_mem_addr,
    output logic [SIZE_WIDTH-1:0]     arb_mem_size,
    output logic [REG_DATA_WIDTH-1:0] arb_mem_wdata,
    output logic                      arb_mem_rd,
    output logic                      arb_mem_wr,
    input  logic [REG_DATA_WIDTH-1:0] mem_arb_rdata,
    input  logic                      mem_arb_ack,
    output logic                      arb_busy
);

    lsu_bus_arb_state_t state, state_next;
    logic grant_rd, grant_wr, starve_hit, killed;

`ifdef LSU_BUS_ARB_STARVATION_GUARD_EN
    lsu_bus_arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve_counter (
        .clk           (clk),
        .rst           (rst),
        .inc           (grant_rd && stbuf_bus_write_req),
        .clr           (grant_wr),
        .limit_reached (starve_hit)
    );
`else
    // Guard compiled out: the limit can never be reached.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE) begin
            if (stbuf_bus_write_req && (drain_req || starve_hit)) begin
                grant_wr = 1'b1;
            end else if (stbuf_bus_read_req && !flush) begin
                grant_rd = 1'b1;
            end else if (stbuf_bus_write_req) begin
                grant_wr = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_rd)      state_next = RD;
                else if (grant_wr) state_next = WR;
            end
            RD, WR: begin
                if (mem_arb_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Payload capture at grant; wdata only moves for writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            killed        <= 1'b0;
            arb_mem_addr  <= '0;
            arb_mem_size  <= '0;
            arb_mem_wdata <= '0;
        end else begin
            killed <= (state == RD) && !mem_arb_ack && (killed || flush);
            if (grant_wr) begin
                arb_mem_addr  <= stbuf_bus_write_addr;
                arb_mem_size  <= stbuf_bus_write_size;
                arb_mem_wdata <= stbuf_bus_data;
            end else if (grant_rd) begin
                arb_mem_addr  <= stbuf_bus_read_addr;
                arb_mem_size  <= stbuf_bus_read_size;
            end
        end
    end

    assign arb_mem_rd          = (state == RD);
    assign arb_mem_wr          = (state == WR);
    assign arb_busy            = (state != IDLE);
    assign bus_stbuf_data      = mem_arb_rdata;
    assign bus_stbuf_write_ack = (state == WR) && mem_arb_ack;
    assign bus_stbuf_read_ack  = (state == RD) && mem_arb_ack && !killed && !flush;

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// Scoreboard bench for lsu_bus_arbiter: queued requesters, a latency-programmable
// memory model, and expected grant/ack queues checked as the DUT responds.
module tb_lsu_bus_arbiter;
    import lsu_bus_arb_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic [ADDR_WIDTH-1:0]     stbuf_bus_read_addr, stbuf_bus_write_addr, arb_mem_addr;
    logic [SIZE_WIDTH-1:0]     stbuf_bus_read_size, stbuf_bus_write_size, arb_mem_size;
    logic [REG_DATA_WIDTH-1:0] bus_stbuf_data, stbuf_bus_data, arb_mem_wdata, mem_arb_rdata;
    logic stbuf_bus_read_req, bus_stbuf_read_ack, stbuf_bus_write_req, bus_stbuf_write_ack;
    logic drain_req, flush, arb_mem_rd, arb_mem_wr, mem_arb_ack, arb_busy;

    lsu_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stbuf_bus_read_addr  (stbuf_bus_read_addr),
        .stbuf_bus_read_size  (stbuf_bus_read_size),
        .stbuf_bus_read_req   (stbuf_bus_read_req),
        .bus_stbuf_data       (bus_stbuf_data),
        .bus_stbuf_read_ack   (bus_stbuf_read_ack),
        .stbuf_bus_write_addr (stbuf_bus_write_addr),
        .stbuf_bus_write_size (stbuf_bus_write_size),
        .stbuf_bus_data       (stbuf_bus_data),
        .stbuf_bus_write_req  (stbuf_bus_write_req),
        .bus_stbuf_write_ack  (bus_stbuf_write_ack),
        .drain_req            (drain_req),
        .flush                (flush),
        .arb_mem_addr         (arb_mem_addr),
        .arb_mem_size         (arb_mem_size),
        .arb_mem_wdata        (arb_mem_wdata),
        .arb_mem_rd           (arb_mem_rd),
        .arb_mem_wr           (arb_mem_wr),
        .mem_arb_rdata        (mem_arb_rdata),
        .mem_arb_ack          (mem_arb_ack),
        .arb_busy             (arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_WIDTH-1:0]     addr;
        logic [SIZE_WIDTH-1:0]     size;
        logic [REG_DATA_WIDTH-1:0] data;
    } req_t;

    req_t rd_q[$];
    req_t wr_q[$];
    byte  exp_grant_q[$];
    req_t mon_r;
    byte  mon_g;

    int checks = 0, errors = 0;
    int mem_lat = 1, mem_cnt = 0;
    int rd_strobes = 0, wr_strobes = 0, rd_acks = 0, wr_acks = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h1000) return 32'hDEADBEEF;
        return a * 3 + 32'h11;
    endfunction

    // Memory: acks in the mem_lat-th strobe cycle of a transaction.
    always begin
        @(posedge clk); #1;
        if (rst || !(arb_mem_rd || arb_mem_wr)) begin
            mem_cnt = 0;
            mem_arb_ack = 1'b0;
        end else begin
            mem_cnt++;
            mem_arb_ack = (mem_cnt == mem_lat);
            mem_arb_rdata = arb_mem_rd ? mem_val(arb_mem_addr) : 32'h0;
        end
    end

    // Requesters: present the queue head until its ack pops it.
    always begin
        @(posedge clk); #1;
        stbuf_bus_read_req  = (rd_q.size() != 0);
        stbuf_bus_write_req = (wr_q.size() != 0);
        if (rd_q.size() != 0) begin
            stbuf_bus_read_addr = rd_q[0].addr;
            stbuf_bus_read_size = rd_q[0].size;
        end
        if (wr_q.size() != 0) begin
            stbuf_bus_write_addr = wr_q[0].addr;
            stbuf_bus_write_size = wr_q[0].size;
            stbuf_bus_data       = wr_q[0].data;
        end
    end

    always @(negedge clk) begin
        if (arb_mem_rd) rd_strobes++;
        if (arb_mem_wr) wr_strobes++;
        if (arb_mem_rd && arb_mem_wr) check("strobe_exclusive", 1, 0);
        if (arb_busy && !busy_prev) begin
            mon_g = arb_mem_wr ? "W" : "R";
            if (exp_grant_q.size() == 0) check("grant_unexpected", mon_g, 0);
            else check("grant_kind", mon_g, exp_grant_q.pop_front());
        end
        if (bus_stbuf_read_ack) begin
            rd_acks++;
            if (rd_q.size() == 0) check("rd_ack_unexpected", 1, 0);
            else begin
                mon_r = rd_q.pop_front();
                check("rd_addr", arb_mem_addr, mon_r.addr);
                check("rd_size", arb_mem_size, mon_r.size);
                check("rd_data", bus_stbuf_data, mon_r.data);
            end
        end
        if (bus_stbuf_write_ack) begin
            wr_acks++;
            if (wr_q.size() == 0) check("wr_ack_unexpected", 1, 0);
            else begin
                mon_r = wr_q.pop_front();
                check("wr_addr", arb_mem_addr, mon_r.addr);
                check("wr_size", arb_mem_size, mon_r.size);
                check("wr_wdata", arb_mem_wdata, mon_r.data);
            end
        end
        busy_prev = arb_busy;
    end

    task automatic push_rd(input logic [31:0] a);
        rd_q.push_back('{addr: a, size: 4'd4, data: mem_val(a)});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_q.push_back('{addr: a, size: 4'd4, data: d});
    endtask

    task automatic clear_counts();
        rd_strobes = 0; wr_strobes = 0; rd_acks = 0; wr_acks = 0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((rd_q.size() != 0 || wr_q.size() != 0 || arb_busy || exp_grant_q.size() != 0) && n < 300);
        check({tag, "_timeout"}, (n >= 300), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_strobe(input string tag, input bit want_wr);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(want_wr ? arb_mem_wr : arb_mem_rd) && n < 50);
        check({tag, "_strobe_timeout"}, (n >= 50), 0);
    endtask

    initial begin
        string seq;
        rst = 1'b1; drain_req = 1'b0; flush = 1'b0;
        mem_arb_ack = 1'b0; mem_arb_rdata = '0;
        stbuf_bus_read_req = 1'b0; stbuf_bus_write_req = 1'b0;
        stbuf_bus_read_addr = '0; stbuf_bus_read_size = '0;
        stbuf_bus_write_addr = '0; stbuf_bus_write_size = '0; stbuf_bus_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd", arb_mem_rd, 0);
        check("rst_wr", arb_mem_wr, 0);
        check("rst_busy", arb_busy, 0);
        check("rst_acks", {bus_stbuf_read_ack, bus_stbuf_write_ack}, 0);
        check("rst_payload", {arb_mem_addr, arb_mem_wdata}, 0);
        check("rst_size", arb_mem_size, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read, 3-cycle memory.
        clear_counts(); mem_lat = 3;
        push_rd(32'h1000); exp_grant_q.push_back("R");
        wait_done("t1");
        check("t1_rd_strobes", rd_strobes, 3);
        check("t1_wr_strobes", wr_strobes, 0);
        check("t1_rd_acks", rd_acks, 1);
        check("t1_wr_acks", wr_acks, 0);

        // Reads and writes both pending, zero-wait memory.
        clear_counts(); mem_lat = 1;
        for (int i = 0; i < 6; i++) push_rd(32'h100 + 32'(i) * 4);
        for (int i = 0; i < 2; i++) push_wr(32'h800 + 32'(i) * 4, 32'hA000_0000 + 32'(i));
`ifdef LSU_BUS_ARB_STARVATION_GUARD_EN
        seq = "RRRRWRRW";
`else
        seq = "RRRRRRWW";
`endif
        for (int i = 0; i < seq.len(); i++) exp_grant_q.push_back(seq[i]);
        wait_done("t2");
        check("t2_rd_acks", rd_acks, 6);
        check("t2_wr_acks", wr_acks, 2);

        // Drain forces the write ahead of a pending read.
        clear_counts(); drain_req = 1'b1;
        push_rd(32'h4000); push_wr(32'h5000, 32'h1234_5678);
        exp_grant_q.push_back("W"); exp_grant_q.push_back("R");
        wait_done("t3");
        drain_req = 1'b0;
        check("t3_acks", {rd_acks[7:0], wr_acks[7:0]}, 16'h0101);

        // Flush while a read is outstanding: strobe held, ack swallowed.
        clear_counts(); mem_lat = 4;
        push_rd(32'h2000); exp_grant_q.push_back("R");
        wait_strobe("t4", 1'b0);
        @(posedge clk); #1;
        flush = 1'b1; rd_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        wait_done("t4");
        check("t4_rd_strobes", rd_strobes, 4);
        check("t4_rd_acks", rd_acks, 0);
        clear_counts(); mem_lat = 1;
        push_rd(32'h3000); exp_grant_q.push_back("R");
        wait_done("t4b");
        check("t4b_rd_acks", rd_acks, 1);

        // Flush coinciding with the memory ack cycle.
        clear_counts(); mem_lat = 2;
        push_rd(32'h2400); exp_grant_q.push_back("R");
        wait_strobe("t5", 1'b0);
        @(posedge clk); #1;
        flush = 1'b1; rd_q.delete();
        @(negedge clk);
        check("t5_mem_ack", mem_arb_ack, 1);
        check("t5_rd_ack", bus_stbuf_read_ack, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        wait_done("t5");
        check("t5_rd_acks", rd_acks, 0);

        // Flush with a lone read in IDLE: no grant until flush drops.
        clear_counts(); mem_lat = 1; flush = 1'b1;
        push_rd(32'h2800); exp_grant_q.push_back("R");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_idle_busy", arb_busy, 0);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        wait_done("t6");
        check("t6_rd_acks", rd_acks, 1);

        // Reset in the middle of a write.
        clear_counts(); mem_lat = 4;
        push_wr(32'h6000, 32'hCAFE_F00D); exp_grant_q.push_back("W");
        wait_strobe("t7", 1'b1);
        @(posedge clk); #1;
        wr_q.delete(); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t7_strobes", {arb_mem_rd, arb_mem_wr}, 0);
        check("t7_busy", arb_busy, 0);
        check("t7_acks", {bus_stbuf_read_ack, bus_stbuf_write_ack}, 0);
        check("t7_payload", {arb_mem_addr, arb_mem_wdata}, 0);
        repeat (6) @(negedge clk);
        check("t7_wr_acks", wr_acks, 0);
        check("t7_idle", arb_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_bus_arbiter.md
# lsu_bus_arbiter

Shares the single-ported data-memory bus between two requesters: store-buffer load-forwarding reads (`stbuf_bus_read_*`) and store-buffer drain writes (`stbuf_bus_write_*`). It sits between `store_buffer` and the data-memory port. Reads have priority to keep load latency low. Writes win when a drain is forced or when reads have starved writes for too long. It owns one outstanding transaction at a time and gates read acks across pipeline flushes.

## Interface
- `STARVE_LIMIT`, default 4: consecutive read grants allowed while a write waits.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `stbuf_bus_read_addr` in `ADDR_WIDTH`: read address.
- `stbuf_bus_read_size` in `SIZE_WIDTH`: read size in bytes.
- `stbuf_bus_read_req` in 1: read request, level.
- `bus_stbuf_data` out `REG_DATA_WIDTH`: read data, valid with `bus_stbuf_read_ack`.
- `bus_stbuf_read_ack` out 1: read done, single-cycle pulse.
- `stbuf_bus_write_addr` in `ADDR_WIDTH`: write address.
- `stbuf_bus_write_size` in `SIZE_WIDTH`: write size.
- `stbuf_bus_data` in `REG_DATA_WIDTH`: write data.
- `stbuf_bus_write_req` in 1: write request, level.
- `bus_stbuf_write_ack` out 1: write done, single-cycle pulse.
- `drain_req` in 1: fence/flush drain; writes take absolute priority.
- `flush` in 1: pipeline flush (`commit_feedback_pack.enable && .flush`).
- `arb_mem_addr` out `ADDR_WIDTH`: registered address.
- `arb_mem_size` out `SIZE_WIDTH`: registered size.
- `arb_mem_wdata` out `REG_DATA_WIDTH`: registered write data.
- `arb_mem_rd` out 1: memory read strobe.
- `arb_mem_wr` out 1: memory write strobe.
- `mem_arb_rdata` in `REG_DATA_WIDTH`: memory read data.
- `mem_arb_ack` in 1: memory completion, single-cycle.
- `arb_busy` out 1: transaction outstanding.

## Operation
- Requester rules:
  - A requester holds req and payload stable until its ack cycle.
  - It deasserts req, or presents a new request, on the cycle after ack.
- State machine:
  - IDLE → RD when a read is granted.
  - IDLE → WR when a write is granted.
  - RD or WR → IDLE on the cycle `mem_arb_ack`=1.
  - No other transitions.
- Grant in IDLE, evaluated combinationally, in this order:
  1. `drain_req` && write_req → write.
  2. write_req && starve_cnt ≥ `STARVE_LIMIT` → write.
  3. read_req && !flush → read.
  4. write_req → write.
  5. Otherwise stay in IDLE.
- At grant:
  - The payload is registered into `arb_mem_addr`/`arb_mem_size`/`arb_mem_wdata`. Wdata is loaded only for writes; it holds its old value for reads.
  - `arb_mem_rd`/`arb_mem_wr` = (state==RD)/(state==WR). Both are never high together.
- Ack forwarding:
  - `bus_stbuf_write_ack` = (state==WR) && `mem_arb_ack`.
  - `bus_stbuf_read_ack` = (state==RD) && `mem_arb_ack` && !killed.
  - `bus_stbuf_data` = `mem_arb_rdata`, passed combinationally.
- Flush:
  - `flush` in RD sets `killed`. The memory read still completes, but its ack is suppressed. `killed` clears on return to IDLE.
  - `flush` during the ack cycle itself also suppresses the ack.
  - Writes are never killed.
- starve_cnt, width `$clog2(STARVE_LIMIT+1)`:
  - Increments, saturating, on each read grant while write_req=1.
  - Clears on any write grant.
- `arb_busy` = state != IDLE.

## Timing
- Reset values:
  - State=IDLE; starve_cnt=0; killed=0.
  - `arb_mem_rd`/`arb_mem_wr`/both acks/`arb_busy`=0.
  - `arb_mem_addr`/`arb_mem_size`/`arb_mem_wdata`=0.
- Reset mid-transaction drops the transaction without an ack. The memory side is reset in the same cycle.
- Latency:
  - Grant in cycle T; memory strobe from T+1.
  - Ack in the same cycle as `mem_arb_ack`, at the earliest T+1.
  - Minimum request-to-ack is 2 cycles. Peak throughput is one transaction per 2 cycles.
- Requests arriving while busy wait. Requests are sampled only in IDLE.
- Read and write arriving together in IDLE with starve_cnt<`STARVE_LIMIT` and no drain: read wins, starve_cnt++.
- `flush` and read_req together in IDLE with no write: no grant; stay in IDLE.

## Configuration
- `LSU_BUS_ARB_STARVATION_GUARD_EN`:
  - Defined: starve_cnt and grant rule 2 are present.
  - Undefined: starve_cnt is removed. Writes win only via `drain_req` or when no read is pending. `STARVE_LIMIT` is ignored.

## Structure
- `lsu_bus_arb_state_t` enum {IDLE, RD, WR} goes in the shared common package.
- Width macros come from config.
- One sub-module, `lsu_bus_arb_starve_counter`: saturating counter with inc/clr/limit-reached, compiled only under the macro.

## Test plan
- Single read 0x1000 size 4, memory acks 3 cycles after strobe: `arb_mem_rd` high 3 cycles at 0x1000; read_ack and data 0xDEADBEEF in one cycle; no write activity.
- Read and write both held, `STARVE_LIMIT`=4, zero-wait memory: grant order R,R,R,R,W; write_ack arrives on the 5th transaction.
- Same stimulus with the macro undefined: reads win for as long as read_req is held; write granted the first IDLE cycle after read_req drops.
- `drain_req`=1 with read and write pending: write granted first regardless of starve_cnt.
- Read outstanding, `flush` pulsed before `mem_arb_ack`: `arb_mem_rd` still held until ack; `bus_stbuf_read_ack` stays 0; next transaction proceeds normally.
- `rst` asserted while in WR: next cycle all strobes, acks and `arb_busy` are 0; no write_ack emitted.
